// File: rtl/coax_tx_pkg.sv
// Shared encodings for the framed coax transmitter: FSM states, start-sequence
// cell kinds, and the parity helper applied to every popped word.
package coax_tx_pkg;

  localparam int WORD_W           = 10;
  localparam int START_CELLS      = 9;
  localparam int P3299_FIRST_BITS = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_SYNC   = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_END    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CELL_HALF_HIGH = 2'd0,
    CELL_ONE       = 2'd1,
    CELL_LOW       = 2'd2,
    CELL_HIGH      = 2'd3
  } cell_kind_t;

  // Start sequence: half-cell high, five '1' cells, low, '1', high.
  function automatic cell_kind_t start_cell(input logic [3:0] idx);
    case (idx)
      4'd0:                         return CELL_HALF_HIGH;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5: return CELL_ONE;
      4'd6:                         return CELL_LOW;
      4'd7:                         return CELL_ONE;
      default:                      return CELL_HIGH;
    endcase
  endfunction

  function automatic logic cell_level(input cell_kind_t kind, input logic second_half);
    case (kind)
      CELL_HALF_HIGH: return 1'b1;
      CELL_ONE:       return second_half;
      CELL_LOW:       return 1'b0;
      CELL_HIGH:      return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

  // Parity covers the sync bit (always 1) plus the full pushed word.
  function automatic logic word_parity(input logic [WORD_W-1:0] d, input logic even);
    return even ? ^{1'b1, d} : ~^{1'b1, d};
  endfunction

endpackage

// File: rtl/coax_tx_if.sv
// Host-side push interface of the framed coax transmitter.
interface coax_tx_if #(parameter int DEPTH = 8);
  import coax_tx_pkg::*;

  logic [WORD_W-1:0]          data;
  logic                       last;
  logic                       strobe;
  logic                       ready;
  logic [$clog2(DEPTH+1)-1:0] level;

  modport master (output data, last, strobe, input ready, level);
  modport slave  (input data, last, strobe, output ready, level);
endinterface

// File: rtl/coax_tx_bit_timer.sv
// Half-cell timer: pulses on the last (and second-to-last) clock of each half bit cell.
module coax_tx_bit_timer #(parameter int CLOCKS_PER_BIT = 8) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic half_tick,
  output logic half_pre_tick
);
  localparam int HALF = CLOCKS_PER_BIT / 2;
  localparam int CW   = $clog2(HALF);

  logic [CW-1:0] cnt_r;

  // Free-running half-cell counter, held at zero while disabled.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt_r <= CW'(0);
    end else if (cnt_r == CW'(HALF - 1)) begin
      cnt_r <= CW'(0);
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign half_tick     = enable && (cnt_r == CW'(HALF - 1));
  assign half_pre_tick = enable && (cnt_r == CW'(HALF - 2));
endmodule

// File: rtl/coax_tx_fifo.sv
// Word FIFO holding {last, data}; reset flushes by clearing pointers and level.
module coax_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 11
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (level_r == LW'(DEPTH));
  assign empty  = (level_r == LW'(0));
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  assign rdata  = mem_r[rd_ptr_r];
  assign level  = level_r;

  // Storage array; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= LW'(0);
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end
endmodule

// File: rtl/coax_tx_framed.sv
// Framed 3270/3299 coax Manchester transmitter with word FIFO and inter-frame gap.
// Optional macro COAX_TX_DELAY_EN adds tx_delay, a CLOCKS_PER_BIT/4-clock delayed tx.
module coax_tx_framed #(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int DEPTH          = 8,
  parameter int GAP_BITS       = 2
) (
  input  logic      clk,
  input  logic      reset,
  coax_tx_if.slave  host,
  input  logic      protocol,
  input  logic      parity,
  output logic      tx,
  output logic      tx_delay,
  output logic      active,
  output logic      underflow,
  output logic      frame_done
);
  import coax_tx_pkg::*;

  localparam int GAP_W = $clog2(GAP_BITS * CLOCKS_PER_BIT + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_BITS * CLOCKS_PER_BIT - 1);

  state_t            state_r;
  logic [3:0]        cell_r;
  logic              half_r;
  logic [3:0]        bit_cnt_r;
  logic [WORD_W-1:0] shreg_r;
  logic              par_bit_r, last_r, first_word_r, proto_r, par_mode_r;
  logic [GAP_W-1:0]  gap_r;
  logic              tx_r, active_r, underflow_r, frame_done_r;

  logic [WORD_W:0]   fifo_rdata_s;
  logic              fifo_full_s, fifo_empty_s, pop_s;
  logic              half_tick_s, half_pre_tick_s;
  logic [WORD_W-1:0] load_bits_s;
  logic [3:0]        load_cnt_s;
  logic              load_par_s;

  coax_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WORD_W + 1)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (host.strobe),
    .pop   (pop_s),
    .wdata ({host.last, host.data}),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (host.level)
  );

  coax_tx_bit_timer #(.CLOCKS_PER_BIT(CLOCKS_PER_BIT)) u_timer (
    .clk           (clk),
    .reset         (reset),
    .enable        (state_r != ST_IDLE),
    .half_tick     (half_tick_s),
    .half_pre_tick (half_pre_tick_s)
  );

  assign host.ready = !fifo_full_s;

  // Pop strobe: the head word is consumed exactly when SYNC is entered.
  always_comb begin
    pop_s = 1'b0;
    if (half_tick_s && half_r) begin
      if (state_r == ST_START && cell_r == 4'(START_CELLS - 1)) begin
        pop_s = 1'b1;
      end else if (state_r == ST_PARITY && !last_r && !fifo_empty_s) begin
        pop_s = 1'b1;
      end else begin
        pop_s = 1'b0;
      end
    end else begin
      pop_s = 1'b0;
    end
  end

  // Word shaping for the head of the FIFO; 3299 first words are left-aligned.
  always_comb begin
    load_par_s = word_parity(fifo_rdata_s[WORD_W-1:0], par_mode_r);
    if (proto_r && first_word_r) begin
      load_cnt_s  = 4'(P3299_FIRST_BITS - 1);
      load_bits_s = {fifo_rdata_s[P3299_FIRST_BITS-1:0], {(WORD_W - P3299_FIRST_BITS){1'b0}}};
    end else begin
      load_cnt_s  = 4'(WORD_W - 1);
      load_bits_s = fifo_rdata_s[WORD_W-1:0];
    end
  end

  // Word datapath: load on pop, shift MSB-first after each data cell.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_r   <= WORD_W'(0);
      bit_cnt_r <= 4'd0;
      par_bit_r <= 1'b0;
      last_r    <= 1'b0;
    end else if (pop_s) begin
      shreg_r   <= load_bits_s;
      bit_cnt_r <= load_cnt_s;
      par_bit_r <= load_par_s;
      last_r    <= fifo_rdata_s[WORD_W];
    end else if (state_r == ST_DATA && half_tick_s && half_r && bit_cnt_r != 4'd0) begin
      shreg_r   <= {shreg_r[WORD_W-2:0], 1'b0};
      bit_cnt_r <= bit_cnt_r - 4'd1;
    end
  end

  // Frame FSM; tx is set one half-cell ahead so the line output is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cell_r       <= 4'd0;
      half_r       <= 1'b0;
      first_word_r <= 1'b0;
      proto_r      <= 1'b0;
      par_mode_r   <= 1'b0;
      gap_r        <= GAP_W'(0);
      tx_r         <= 1'b0;
      active_r     <= 1'b0;
      underflow_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      underflow_r  <= 1'b0;
      frame_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (gap_r != GAP_W'(0)) begin
            gap_r <= gap_r - GAP_W'(1);
          end else if (!fifo_empty_s) begin
            proto_r      <= protocol;
            par_mode_r   <= parity;
            first_word_r <= 1'b1;
            state_r      <= ST_START;
            cell_r       <= 4'd0;
            half_r       <= 1'b0;
            tx_r         <= 1'b1;
            active_r     <= 1'b1;
          end
        end
        ST_START: begin
          if (half_tick_s) begin
            if (cell_r == 4'd0 || half_r) begin
              if (cell_r == 4'(START_CELLS - 1)) begin
                state_r      <= ST_SYNC;
                first_word_r <= 1'b0;
                half_r       <= 1'b0;
                tx_r         <= 1'b0;
              end else begin
                cell_r <= cell_r + 4'd1;
                half_r <= 1'b0;
                tx_r   <= cell_level(start_cell(cell_r + 4'd1), 1'b0);
              end
            end else begin
              half_r <= 1'b1;
              tx_r   <= cell_level(start_cell(cell_r), 1'b1);
            end
          end
        end
        ST_SYNC: begin
          if (half_tick_s) begin
            if (!half_r) begin
              half_r <= 1'b1;
              tx_r   <= 1'b1;
            end else begin
              state_r <= ST_DATA;
              half_r  <= 1'b0;
              tx_r    <= ~shreg_r[WORD_W-1];
            end
          end
        end
        ST_DATA: begin
          if (half_tick_s) begin
            if (!half_r) begin
              half_r <= 1'b1;
              tx_r   <= shreg_r[WORD_W-1];
            end else if (bit_cnt_r == 4'd0) begin
              state_r <= ST_PARITY;
              half_r  <= 1'b0;
              tx_r    <= ~par_bit_r;
            end else begin
              half_r <= 1'b0;
              tx_r   <= ~shreg_r[WORD_W-2];
            end
          end
        end
        ST_PARITY: begin
          if (half_tick_s) begin
            if (!half_r) begin
              half_r <= 1'b1;
              tx_r   <= par_bit_r;
            end else if (!last_r && !fifo_empty_s) begin
              state_r <= ST_SYNC;
              half_r  <= 1'b0;
              tx_r    <= 1'b0;
            end else begin
              underflow_r <= !last_r;
              state_r     <= ST_END;
              cell_r      <= 4'd0;
              half_r      <= 1'b0;
              tx_r        <= 1'b1;
            end
          end
        end
        ST_END: begin
          // End sequence: one high-then-low cell followed by two high cells.
          if (half_tick_s) begin
            if (!half_r) begin
              half_r <= 1'b1;
              tx_r   <= (cell_r != 4'd0);
            end else if (cell_r == 4'd2) begin
              state_r  <= ST_IDLE;
              cell_r   <= 4'd0;
              half_r   <= 1'b0;
              tx_r     <= 1'b0;
              active_r <= 1'b0;
              gap_r    <= GAP_LOAD;
            end else begin
              cell_r <= cell_r + 4'd1;
              half_r <= 1'b0;
              tx_r   <= 1'b1;
            end
          end
          if (half_pre_tick_s && half_r && cell_r == 4'd2) begin
            frame_done_r <= 1'b1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          tx_r     <= 1'b0;
          active_r <= 1'b0;
        end
      endcase
    end
  end

  assign tx         = tx_r;
  assign active     = active_r;
  assign underflow  = underflow_r;
  assign frame_done = frame_done_r;

`ifdef COAX_TX_DELAY_EN
  localparam int DLY = CLOCKS_PER_BIT / 4;
  logic [DLY-1:0] dly_r;

  // Pre-emphasis delay line behind the registered line output.
  always_ff @(posedge clk) begin
    if (reset) begin
      dly_r <= DLY'(0);
    end else begin
      dly_r <= DLY'({dly_r, tx_r});
    end
  end

  assign tx_delay = dly_r[DLY-1];
`else
  assign tx_delay = 1'b0;
`endif
endmodule

// File: tb/tb_coax_tx_framed.sv
// Scoreboard bench: a waveform model built from the line-code rules feeds a queue
// that a negedge monitor consumes frame by frame.
module tb_coax_tx_framed;
  localparam int CPB = 8, DEPTH = 8, GAP_BITS = 2, HALF = CPB / 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic protocol = 1'b0, parity = 1'b0;
  logic tx, tx_delay, active, underflow, frame_done;

  coax_tx_if #(.DEPTH(DEPTH)) host ();

  coax_tx_framed #(.CLOCKS_PER_BIT(CPB), .DEPTH(DEPTH), .GAP_BITS(GAP_BITS)) dut (
    .clk(clk), .reset(reset), .host(host), .protocol(protocol), .parity(parity),
    .tx(tx), .tx_delay(tx_delay), .active(active), .underflow(underflow),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit exp_bits[$];
  int exp_len[$];
  bit exp_uf[$];
  logic [9:0] fw [0:15];
  int fn;

  bit in_frame = 1'b0;
  int cur_len, cur_mis, cur_fd, cur_uf, last_frame_len;
  int idle_err = 0, dly_mis = 0;
  bit h0 = 1'b0, h1 = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic put_half(input bit b);
    repeat (HALF) exp_bits.push_back(b);
  endtask

  task automatic put_cell(input bit b);
    put_half(~b);
    put_half(b);
  endtask

  // Expected line waveform of one frame built from fw[0:fn-1].
  task automatic model_frame(input bit proto, input bit par, input bit uf);
    int len0, nb;
    logic [9:0] w;
    bit p;
    len0 = exp_bits.size();
    put_half(1'b1);
    repeat (5) put_cell(1'b1);
    put_half(1'b0); put_half(1'b0);
    put_cell(1'b1);
    put_half(1'b1); put_half(1'b1);
    for (int i = 0; i < fn; i++) begin
      w  = fw[i];
      nb = (proto && i == 0) ? 6 : 10;
      put_cell(1'b1);
      for (int k = nb - 1; k >= 0; k--) put_cell(w[k]);
      p = par ? ^{1'b1, w} : ~^{1'b1, w};
      put_cell(p);
    end
    put_half(1'b1); put_half(1'b0);
    repeat (4) put_half(1'b1);
    exp_len.push_back(exp_bits.size() - len0);
    exp_uf.push_back(uf);
  endtask

  task automatic push_word(input logic [9:0] d, input bit l);
    host.data = d; host.last = l; host.strobe = 1'b1;
    @(posedge clk); #1;
    host.strobe = 1'b0;
  endtask

  task automatic push_frame(input bit with_last);
    for (int i = 0; i < fn; i++) push_word(fw[i], with_last && (i == fn - 1));
  endtask

  task automatic wait_active(input bit val, input string name, input int budget);
    int n = 0;
    while (active !== val && n < budget) begin @(posedge clk); #1; n++; end
    checks++;
    if (active !== val) begin
      failures++;
      $display("FAIL %s timeout active=%0b required=%0b", name, active, val);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_len.size() != 0 || in_frame) && n < budget) begin @(posedge clk); #1; n++; end
    check({name, "_pending_frames"}, exp_len.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    check({name, "_level_after"}, host.level, 0);
  endtask

  // Monitor: per-frame waveform, length, pulse counts; idle and delay-line checks.
  always @(negedge clk) begin
    if (reset) begin
      in_frame = 1'b0;
      h0 = 1'b0; h1 = 1'b0;
    end else begin
`ifdef COAX_TX_DELAY_EN
      if (tx_delay !== h1) dly_mis++;
`else
      if (tx_delay !== 1'b0) dly_mis++;
`endif
      h1 = h0; h0 = tx;
      if (active) begin
        if (!in_frame) begin
          in_frame = 1'b1; cur_len = 0; cur_mis = 0; cur_fd = 0; cur_uf = 0;
        end
        cur_len++;
        if (exp_bits.size() > 0) begin
          if (tx !== exp_bits.pop_front()) cur_mis++;
        end else begin
          cur_mis++;
        end
        if (frame_done) cur_fd++;
        if (underflow) cur_uf++;
      end else begin
        if (tx !== 1'b0 || frame_done || underflow) idle_err++;
        if (in_frame) begin
          in_frame = 1'b0;
          last_frame_len = cur_len;
          if (exp_len.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_frame actual_len=%0d required=none", cur_len);
          end else begin
            check("frame_len", cur_len, exp_len.pop_front());
            check("frame_tx_wave_mismatches", cur_mis, 0);
            check("frame_done_pulses", cur_fd, 1);
            check("underflow_pulses", cur_uf, exp_uf.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int n, gap, gap_tx, fd_cnt, act_cnt, nfr;
    host.strobe = 1'b0; host.data = 10'h000; host.last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 0);
    check("rst_tx_delay", tx_delay, 0);
    check("rst_active", active, 0);
    check("rst_underflow", underflow, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_level", host.level, 0);
    check("rst_ready", host.ready, 1);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single word, latency and 188-clock frame.
    protocol = 1'b0; parity = 1'b1;
    fn = 1; fw[0] = 10'h155;
    model_frame(1'b0, 1'b1, 1'b0);
    host.data = 10'h155; host.last = 1'b1; host.strobe = 1'b1;
    @(posedge clk); #1;
    host.strobe = 1'b0;
    check("latency_n1_tx", tx, 0);
    @(posedge clk); #1;
    check("latency_n2_tx", tx, 1);
    check("latency_n2_active", active, 1);
    wait_drain("single", 400);
    check("single_active_clocks", last_frame_len, 188);

    // Three words queued before the frame starts.
    protocol = 1'b0; parity = 1'b0;
    fn = 3; fw[0] = 10'h001; fw[1] = 10'h3FF; fw[2] = 10'h2AA;
    model_frame(1'b0, 1'b0, 1'b0);
    push_frame(1'b1);
    wait_drain("three_words", 800);

    // 3299 mode; protocol/parity flipped mid-frame must not matter.
    protocol = 1'b1; parity = 1'b0;
    fn = 2; fw[0] = 10'h3C5; fw[1] = 10'h100;
    model_frame(1'b1, 1'b0, 1'b0);
    push_frame(1'b1);
    wait_active(1'b1, "p3299_start", 50);
    protocol = 1'b0; parity = 1'b1;
    wait_drain("p3299", 800);

    // Fill to DEPTH without last; ninth strobe dropped; underflow after word 8.
    protocol = 1'b0; parity = 1'b1;
    fn = DEPTH;
    for (int i = 0; i < DEPTH; i++) fw[i] = 10'($urandom);
    model_frame(1'b0, 1'b1, 1'b1);
    push_frame(1'b0);
    check("full_level", host.level, DEPTH);
    check("full_ready", host.ready, 0);
    push_word(10'h2DB, 1'b0);
    check("full_drop_level", host.level, DEPTH);
    wait_drain("underflow", 2000);

    // Two queued frames separated by exactly the gap.
    fn = 2; fw[0] = 10'h0F0; fw[1] = 10'h30C;
    model_frame(1'b0, 1'b1, 1'b0);
    push_frame(1'b1);
    fn = 1; fw[0] = 10'h1E7;
    model_frame(1'b0, 1'b1, 1'b0);
    push_frame(1'b1);
    wait_active(1'b1, "gap_first_start", 50);
    wait_active(1'b0, "gap_first_end", 600);
    gap = 0; gap_tx = 0;
    while (!active && gap < 100) begin
      if (tx) gap_tx++;
      gap++;
      @(posedge clk); #1;
    end
    check("gap_clocks", gap, GAP_BITS * CPB);
    check("gap_tx_high", gap_tx, 0);
    wait_drain("gap", 600);

    // Randomised batches of one or two frames.
    for (int b = 0; b < 12; b++) begin
      protocol = 1'($urandom); parity = 1'($urandom);
      nfr = $urandom_range(1, 2);
      for (int f = 0; f < nfr; f++) begin
        fn = $urandom_range(1, 3);
        for (int i = 0; i < fn; i++) fw[i] = 10'($urandom);
        model_frame(protocol, parity, 1'b0);
        push_frame(1'b1);
      end
      wait_drain("random", 1500);
    end

    // Reset during DATA of word 2 aborts the frame.
    protocol = 1'b0; parity = 1'b0;
    fn = 3; fw[0] = 10'h123; fw[1] = 10'h234; fw[2] = 10'h345;
    push_frame(1'b1);
    wait_active(1'b1, "abort_start", 50);
    repeat (180) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_tx", tx, 0);
    check("abort_active", active, 0);
    check("abort_level", host.level, 0);
    check("abort_ready", host.ready, 1);
    check("abort_frame_done", frame_done, 0);
    reset = 1'b0;
    fd_cnt = 0; act_cnt = 0;
    for (n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (frame_done) fd_cnt++;
      if (active) act_cnt++;
    end
    check("abort_no_frame_done", fd_cnt, 0);
    check("abort_no_restart", act_cnt, 0);

    check("idle_line_errors", idle_err, 0);
    check("tx_delay_mismatches", dly_mis, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/coax_tx_framed.md
Name: coax_tx_framed

Overview:
- Next-generation 3270/3299 coax transmitter: Manchester line encoder plus an internal word FIFO of DEPTH entries, with explicit end-of-frame marking.
- Frames are delimited by a per-word `last` flag rather than by the producer running dry. An underrun mid-frame is detected and flagged.
- Protocol/parity modes are latched per frame. A minimum inter-frame gap is enforced.
- Sits between the host command interface and the line driver; replaces the single-register transmitter.

Parameters:
- CLOCKS_PER_BIT, 8: clocks per bit cell; even, >= 4.
- DEPTH, 8: FIFO depth in words; power of 2, >= 2.
- GAP_BITS, 2: minimum idle bit cells (tx=0) between end of one frame and start of the next; >= 1.

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- data  in  10  word to send, MSB first
- last  in  1  word is final word of its frame; sampled with data
- strobe  in  1  push request
- ready  out  1  FIFO not full
- level  out  $clog2(DEPTH+1)  FIFO occupancy
- protocol  in  1  1 = 3299 mode (first word of frame carries 6 bits)
- parity  in  1  1 = even parity over sync+data, 0 = odd
- tx  out  1  registered line output
- tx_delay  out  1  delayed copy of tx (see Optional Feature)
- active  out  1  frame in progress
- underflow  out  1  one-clock pulse: FIFO empty after a non-last word
- frame_done  out  1  one-clock pulse on last clock of the end sequence

Behaviour:
- Reset values: tx=0, tx_delay=0, active=0, underflow=0, frame_done=0, FIFO empty, level=0, ready=1.
- Reset mid-frame: abort immediately, flush FIFO, state IDLE. No end sequence is sent.
- Push:
  - Occurs when strobe && ready; {last, data} is written.
  - Pop occurs at SYNC entry; each pop computes parity = parity_latched ? ^{1,data} : ~^{1,data}.
  - Push and pop in the same cycle are both honoured and level is unchanged.
  - When full, ready=0 and strobe is ignored.
- Cell encoding: half = CLOCKS_PER_BIT/2.
  - Bit value b is sent as ~b for the first half and b for the second half.
  - "Low cell" = tx 0 for the full cell; "high cell" = tx 1 for the full cell.
- States and transitions:
  - IDLE: when FIFO is non-empty and the gap counter is expired, latch protocol and parity, then go to START.
  - START: half-cell high; five '1' cells; low cell; one '1' cell; high cell. Then SYNC.
  - SYNC: one '1' cell. Loads bit_count = (protocol_latched && first_word) ? 5 : 9. In that case the word is left-aligned as {data[5:0],4'b0}.
  - DATA: bit_count+1 cells, MSB first, then PARITY.
  - PARITY: one cell carrying the popped parity bit. Then:
    - last=1 → END.
    - last=0 and FIFO non-empty → SYNC, next word back-to-back with no gap.
    - last=0 and FIFO empty → underflow pulse, then END.
  - END: a cell high-then-low; two high cells; then tx=0, frame_done pulse, load gap counter = GAP_BITS*CLOCKS_PER_BIT, go to IDLE.
- active:
  - Registered; rises on the same clock as the first tx=1 of START.
  - Falls on the same clock tx returns to 0 after END (no trailing cycle).
- Latency: strobe at cycle N into an empty FIFO in IDLE (gap expired) → tx=1 at cycle N+2.
- protocol/parity changes mid-frame are ignored until the next frame.
- Words pushed during END or GAP wait in the FIFO and start the next frame.

Optional Feature:
- Macro COAX_TX_DELAY_EN.
- Defined: tx_delay = tx delayed by CLOCKS_PER_BIT/4 clocks through a shift register, for the line-driver pre-emphasis stage. Reset clears the shift register.
- Undefined: tx_delay tied 0 and no shift register is instantiated.

Decomposition:
- Package coax_tx_pkg holds:
  - state encoding localparams (IDLE, START, SYNC, DATA, PARITY, END);
  - start-sequence cell pattern constants (length 9, per-cell kind);
  - the 3299 first-word width 6.
- Bit timing reuses the existing coax_tx_bit_timer unchanged.
- One new sub-module is natural: coax_tx_fifo (DEPTH x 11 bits; push/pop, full/empty, level; synchronous reset flush).

Test Plan:
- Single word 10'h155, last=1, parity=1, protocol=0, CPB=8 → active high exactly 188 clocks; parity cell = 0; frame_done pulses once; level returns to 0.
- Three words 10'h001, 10'h3FF, 10'h2AA(last), all pushed before the frame starts → one frame: one START, 3 SYNC/DATA/PARITY groups back-to-back, one END.
- protocol=1, first word 10'h3C5, second 10'h100(last) → first group sends 6 data bits 000101; second sends 10 bits. Changing protocol to 0 mid-frame has no effect.
- Push DEPTH=8 words without last while tx stalled → ready=0 at level 8; a 9th strobe is dropped. After the 8th word, underflow pulses once and END follows.
- Two frames queued back-to-back, GAP_BITS=2 → tx=0 and active=0 for exactly 16 clocks between frames.
- Assert reset during DATA of word 2 → next clock tx=0, active=0, level=0, ready=1; no frame_done pulse. With COAX_TX_DELAY_EN, tx_delay equals tx shifted by 2 clocks.
